kyber_parse_sampler: RTL and testbench
======================================

Name: kyber_parse_sampler

Overview:
- Uniform rejection sampler (Kyber "Parse"). Consumes the 4032-bit SHAKE-128 XOF output block and emits 256 coefficients in [0, Q-1], one per transfer, over a valid/ready stream.
- It is the reader end of the XOF output interface. It sits between the SHAKE-128 block and the matrix-A coefficient store.

Parameters:
- Q, 3329, modulus; a candidate is accepted iff it is < Q.
- N_COEF, 256, coefficients produced per polynomial.
- IN_BYTES, 504, XOF bytes available; 504/3 = 168 triples.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins sampling. Accepted only in IDLE, DONE or SHORT.
- Z_rv  in  4032  XOF output. Byte i = Z_rv[8i +: 8], with bit 8i as the byte MSB. Must be held stable from start until done or short.
- coef  out  12  current coefficient.
- coef_valid  out  1  coef is valid.
- coef_ready  in  1  downstream accepts; transfer occurs when coef_valid & coef_ready.
- coef_idx  out  8  index 0..255 of the coefficient on coef.
- busy  out  1  high in D1/D2.
- done  out  1  level; 256 coefficients delivered.
- short  out  1  level; bytes exhausted before 256 coefficients were produced.

Behaviour:
- Reset (async): state=IDLE, triple index t=0, count=0. coef=0, coef_valid=0, coef_idx=0, busy=0, done=0, short=0.
- Candidate formation for triple t, with bytes b0=byte 3t, b1=byte 3t+1, b2=byte 3t+2:
  - d1 = b0 + 256*(b1 & 0xF).
  - d2 = (b1 >> 4) + 16*b2.
  - Both are 12-bit unsigned; no modular reduction.
- States: IDLE, D1, D2, DONE, SHORT.
- IDLE/DONE/SHORT + start -> D1 at the next edge. On entry, t=0, count=0, done=0, short=0.
- D1:
  - coef=d1, coef_valid=(d1<Q) (combinational from state and t), coef_idx=count.
  - If valid and not ready: hold D1 (stall). All outputs stay stable.
  - If transfer: count++. If the new count == N_COEF -> DONE (d2 discarded); else -> D2.
  - If rejected (d1>=Q): -> D2 next cycle, no valid.
- D2:
  - Same rules with d2.
  - On leaving D2 (transfer or reject): t++.
  - If count reaches N_COEF -> DONE.
  - Else if the new t == IN_BYTES/3 -> SHORT.
  - Else -> D1.
- Throughput is one candidate per cycle absent backpressure. First coef_valid can occur the cycle after start.
- done and short are registered levels that hold until the next accepted start or rst. coef_valid=0 outside D1/D2.
- start while busy is ignored.
- rst mid-operation aborts immediately to the reset state. No partial-state retention.
- coef_ready is ignored when coef_valid=0.

Test Plan:
- All-zero Z_rv, coef_ready=1, start at cycle 0:
  - 256 transfers of coef=0 with coef_idx 0..255 on consecutive cycles 1..256 (128 triples used).
  - done=1 from cycle 257; busy=0.
- All-0xFF Z_rv: every candidate is 4095 and rejected; coef_valid never asserts; short=1 after 336 candidate cycles; done=0.
- Boundary values:
  - Triple (0x00,0x0D,0x00): d1=3328 accepted, d2=0 accepted.
  - Triple (0x01,0x0D,0x00): d1=3329 rejected, d2=0 accepted as the next coef_idx.
  - Triple (0xFF,0xFF,0xCF): d1=4095 rejected, d2=0xCFF=3327 accepted.
- Backpressure: hold coef_ready=0 for 5 cycles on coef_idx 7. coef, coef_idx and coef_valid stay stable; the transfer completes on the first ready cycle; no coefficient is lost or duplicated.
- Count ends on d1: arrange the 256th accept at d1 of a triple. DONE is entered the next cycle, the d2 of that triple is never presented, and t stops advancing.
- Reset and restart:
  - Assert rst at coef_idx 100: all outputs zero immediately.
  - A new start replays from coef_idx 0.
  - start pulsed in D2 is ignored.

Source files
------------

// File: rtl/kyber_parse_sampler.sv
// Kyber Parse: uniform rejection sampler over a 504-byte SHAKE-128 block.
// Emits 256 coefficients below Q on a valid/ready stream, one candidate per cycle.
module kyber_parse_sampler #(
    parameter int Q        = 3329,
    parameter int N_COEF   = 256,
    parameter int IN_BYTES = 504
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [IN_BYTES*8-1:0]   Z_rv,
    output logic [11:0]             coef,
    output logic                    coef_valid,
    input  logic                    coef_ready,
    output logic [7:0]              coef_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    short
);

    localparam logic [7:0]  N_TRIPLES = 8'(IN_BYTES / 3);
    localparam logic [8:0]  N_TARGET  = 9'(N_COEF);
    localparam logic [11:0] Q_W       = 12'(Q);

    typedef enum logic [2:0] {
        IDLE,
        D1,
        D2,
        DONE,
        SHORT
    } state_t;

    state_t      state, state_n;
    logic [7:0]  t, t_n;
    logic [8:0]  count, count_n;
    logic        done_n, short_n;

    logic [11:0] base;
    logic [23:0] triple;
    logic [7:0]  b0, b1, b2;
    logic [11:0] d1, d2, cand;
    logic        cand_ok;
    logic        in_run;

    assign base   = 12'(t) * 12'd24;
    assign triple = Z_rv[base +: 24];

    // Bytes arrive with bit 8i as their MSB, so each byte is bit-reversed.
    always_comb begin
        b0 = '0;
        b1 = '0;
        b2 = '0;
        for (int k = 0; k < 8; k++) begin
            b0[7-k] = triple[k];
            b1[7-k] = triple[8+k];
            b2[7-k] = triple[16+k];
        end
    end

    assign d1      = {b1[3:0], b0};
    assign d2      = {b2, b1[7:4]};
    assign cand    = (state == D2) ? d2 : d1;
    assign cand_ok = cand < Q_W;
    assign in_run  = (state == D1) || (state == D2);

    assign busy       = in_run;
    assign coef_valid = in_run && cand_ok;
    assign coef       = in_run ? cand : 12'd0;
    assign coef_idx   = in_run ? count[7:0] : 8'd0;

    always_comb begin
        state_n = state;
        t_n     = t;
        count_n = count;
        done_n  = done;
        short_n = short;
        unique case (state)
            IDLE, DONE, SHORT: begin
                if (start) begin
                    state_n = D1;
                    t_n     = '0;
                    count_n = '0;
                    done_n  = 1'b0;
                    short_n = 1'b0;
                end
            end
            D1: begin
                if (!cand_ok) begin
                    state_n = D2;
                end else if (coef_ready) begin
                    count_n = count + 9'd1;
                    if (count_n == N_TARGET) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = D2;
                    end
                end
            end
            D2: begin
                if (!cand_ok || coef_ready) begin
                    t_n = t + 8'd1;
                    if (cand_ok)
                        count_n = count + 9'd1;
                    if (count_n == N_TARGET) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else if (t_n == N_TRIPLES) begin
                        state_n = SHORT;
                        short_n = 1'b1;
                    end else begin
                        state_n = D1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            t     <= '0;
            count <= '0;
            done  <= 1'b0;
            short <= 1'b0;
        end else begin
            state <= state_n;
            t     <= t_n;
            count <= count_n;
            done  <= done_n;
            short <= short_n;
        end
    end

endmodule

// File: tb/tb_kyber_parse_sampler.sv
// Scoreboard bench for kyber_parse_sampler: a reference Parse model fills
// the expected queue, the monitor pops and compares on every transfer.
module tb_kyber_parse_sampler;

    localparam int NB = 504;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [NB*8-1:0] z_rv = '0;
    logic [11:0]     coef;
    logic            coef_valid;
    logic            coef_ready = 1'b0;
    logic [7:0]      coef_idx;
    logic            busy;
    logic            done;
    logic            short;

    kyber_parse_sampler dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .Z_rv       (z_rv),
        .coef       (coef),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_idx   (coef_idx),
        .busy       (busy),
        .done       (done),
        .short      (short)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] c;
        logic [7:0]  i;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] zb[NB];
    int         exp_cyc;
    bit         exp_done;
    bit         exp_short;
    int         tests = 0;
    int         fails = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        tests++;
        if (obs !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Byte i lands in z_rv[8i +: 8] with its MSB at bit 8i.
    task automatic pack();
        for (int i = 0; i < NB; i++)
            for (int k = 0; k < 8; k++)
                z_rv[8*i + 7 - k] = zb[i][k];
    endtask

    task automatic model();
        int          cnt;
        logic [11:0] d1, d2;
        exp_q.delete();
        cnt     = 0;
        exp_cyc = 0;
        for (int t = 0; t < NB / 3 && cnt < 256; t++) begin
            d1 = {zb[3*t+1][3:0], zb[3*t]};
            d2 = {zb[3*t+2], zb[3*t+1][7:4]};
            exp_cyc++;
            if (d1 < 12'd3329) begin
                exp_q.push_back({d1, 8'(cnt)});
                cnt++;
            end
            if (cnt == 256) break;
            exp_cyc++;
            if (d2 < 12'd3329) begin
                exp_q.push_back({d2, 8'(cnt)});
                cnt++;
            end
        end
        exp_done  = (cnt == 256);
        exp_short = !exp_done;
    endtask

    always @(negedge clk) begin
        if (!rst && coef_valid) begin
            if (exp_q.size() == 0) begin
                chk("extra_coef", 1, 0);
            end else begin
                chk("coef", int'(coef), int'(exp_q[0].c));
                chk("coef_idx", int'(coef_idx), int'(exp_q[0].i));
                if (coef_ready)
                    void'(exp_q.pop_front());
            end
        end
    end

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < NB; i++)
            zb[i] = v;
    endtask

    task automatic set_triple(input int t, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] c);
        zb[3*t]   = a;
        zb[3*t+1] = b;
        zb[3*t+2] = c;
    endtask

    // mode 0: always ready, 1: random ready, 2: 5-cycle stall on idx 7
    task automatic run_case(input string name, input int mode, input bit glitch);
        int edges;
        int hold;
        pack();
        model();
        hold = 0;
        @(posedge clk);
        #1 start = 1'b1;
        coef_ready = 1'b1;
        @(posedge clk);
        edges = 1;
        #1 start = 1'b0;
        while (!(done || short) && edges < 3000) begin
            if (glitch)
                start = (edges == 2);
            case (mode)
                1: coef_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (coef_valid && coef_idx == 8'd7 && hold < 5) begin
                        coef_ready = 1'b0;
                        hold++;
                    end else begin
                        coef_ready = 1'b1;
                    end
                end
                default: coef_ready = 1'b1;
            endcase
            @(posedge clk);
            edges++;
            #1;
        end
        start = 1'b0;
        coef_ready = 1'b1;
        chk({name, "_timeout"}, int'(edges < 3000), 1);
        chk({name, "_done"}, int'(done), int'(exp_done));
        chk({name, "_short"}, int'(short), int'(exp_short));
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_left"}, exp_q.size(), 0);
        if (mode == 0)
            chk({name, "_cycles"}, edges, exp_cyc + 1);
        if (mode == 2)
            chk({name, "_stalls"}, hold, 5);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_valid_idle"}, int'(coef_valid), 0);
        chk({name, "_done_hold"}, int'(done), int'(exp_done));
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_coef"}, int'(coef), 0);
        chk({name, "_valid"}, int'(coef_valid), 0);
        chk({name, "_idx"}, int'(coef_idx), 0);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_done"}, int'(done), 0);
        chk({name, "_short"}, int'(short), 0);
    endtask

    initial begin
        int edges;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        fill(8'h00);
        run_case("zeros", 0, 1'b0);

        fill(8'hFF);
        run_case("ones", 0, 1'b0);

        fill(8'h00);
        set_triple(0, 8'h00, 8'h0D, 8'h00);
        set_triple(1, 8'h01, 8'h0D, 8'h00);
        set_triple(2, 8'hFF, 8'hFF, 8'hCF);
        run_case("bound", 0, 1'b0);

        for (int i = 0; i < NB; i++)
            zb[i] = 8'($urandom);
        run_case("bp7", 2, 1'b0);

        for (int i = 0; i < NB; i++)
            zb[i] = 8'($urandom);
        run_case("rand_rdy", 1, 1'b0);

        fill(8'h00);
        set_triple(0, 8'h01, 8'h0D, 8'h00);
        run_case("end_d1", 0, 1'b0);

        fill(8'h00);
        pack();
        model();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        edges = 0;
        while (!(coef_valid && coef_idx == 8'd100) && edges < 1000) begin
            @(posedge clk);
            edges++;
            #1;
        end
        chk("abort_reach", int'(edges < 1000), 1);
        rst = 1'b1;
        #1;
        chk_zero("abort");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;

        run_case("restart", 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
